// File: rtl/ldlt_solver.sv
`default_nettype none
// ============================================================================
//  Module   : ldlt_solver
//  Purpose  : Streaming LDL^T factorisation of a symmetric MAT_DIM x MAT_DIM
//             fixed-point matrix, with an optional solve of A.x = b.
//             The lower triangle is stored column-major.
//             d_j lives on the diagonal until FWD replaces it with z_j.
//             b is overwritten by y and then by x.
//  Latency  : o_valid rises exactly L clock edges after the edge that accepts
//             the last input word.
//               mode 0 : L = N(N+1)(N+2)/6           (N=3 -> 10, N=6 -> 56)
//               mode 1 : L = N(N+1)(N+2)/6 + N(N+1)  (N=3 -> 22, N=6 -> 98)
//  Revision : 1.0  initial parametrised release
// ============================================================================
module ldlt_solver #(
    parameter int DATA_LEN = 32,
    parameter int FRACTION = 16,
    parameter int MAT_DIM  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_mode,
    input  logic                i_valid,
    input  logic [DATA_LEN-1:0] i_data,
    output logic                o_ready,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [DATA_LEN-1:0] o_data,
    output logic                o_busy,
    output logic                o_err
);
    localparam int TRI = MAT_DIM * (MAT_DIM + 1) / 2;
    localparam int TOT = TRI + MAT_DIM;
    localparam int AW  = DATA_LEN + FRACTION;   // accumulator width
    localparam int DW  = AW + 1;                // divider width, no -MIN/-1 wrap
    localparam int PW  = 2 * DATA_LEN;          // full product width
    localparam int IW  = $clog2(TOT);
    localparam int TIW = $clog2(TRI);
    localparam int CW  = $clog2(MAT_DIM);

    localparam logic [CW-1:0]        C_LAST     = CW'(MAT_DIM - 1);
    localparam logic [IW-1:0]        C_TRI      = IW'(TRI);
    localparam logic [IW-1:0]        C_TRI_LAST = IW'(TRI - 1);
    localparam logic [IW-1:0]        C_TOT_LAST = IW'(TOT - 1);
    localparam logic [IW-1:0]        C_N_LAST   = IW'(MAT_DIM - 1);
    localparam logic [DATA_LEN-1:0]  C_MAXW     = {1'b0, {(DATA_LEN-1){1'b1}}};
    localparam logic [DATA_LEN-1:0]  C_MINW     = {1'b1, {(DATA_LEN-1){1'b0}}};
    localparam logic signed [DW-1:0] C_HI       = DW'(C_MAXW);
    localparam logic signed [DW-1:0] C_LO       = DW'($signed(C_MINW));

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FACT, S_FWD, S_BWD, S_OUT} state_t;

    // Flat column-major position of lower-triangle element (r, c), r >= c.
    function automatic logic [TIW-1:0] tidx(input logic [CW-1:0] r, input logic [CW-1:0] c);
        int ri, ci;
        ri = int'(r);
        ci = int'(c);
        return TIW'(ci * MAT_DIM - (ci * (ci - 1)) / 2 + ri - ci);
    endfunction

    // Fixed-point product: full width, arithmetic shift floors toward -inf.
    function automatic logic signed [AW-1:0] mul_q(input logic signed [DATA_LEN-1:0] a,
                                                    input logic signed [DATA_LEN-1:0] b);
        logic signed [PW-1:0] p;
        p = PW'(a) * PW'(b);
        return AW'(p >>> FRACTION);
    endfunction

    function automatic logic [DATA_LEN-1:0] sat(input logic signed [DW-1:0] v);
        if (v > C_HI)      return C_MAXW;
        else if (v < C_LO) return C_MINW;
        else               return v[DATA_LEN-1:0];
    endfunction

    // Fixed-point quotient, truncated toward zero; a zero divisor yields 0.
    function automatic logic signed [DW-1:0] div_q(input logic signed [DATA_LEN-1:0] n,
                                                    input logic signed [DATA_LEN-1:0] d);
        logic signed [DW-1:0] nn, dd;
        nn = DW'(n) <<< FRACTION;
        dd = DW'(d);
        if (d == '0) return '0;
        return nn / dd;
    endfunction

    state_t                      state_q, state_d;
    logic                        mode_q, mode_d, err_q, err_d, first_q, first_d;
    logic [IW-1:0]               cnt_q, cnt_d;
    logic [CW-1:0]               j_q, j_d, i_q, i_d, k_q, k_d;
    logic signed [AW-1:0]        acc_q, acc_d, acc_cur, term;
    logic signed [DATA_LEN-1:0]  mat_q [TRI];
    logic signed [DATA_LEN-1:0]  mat_d [TRI];
    logic signed [DATA_LEN-1:0]  vec_q [MAT_DIM];
    logic signed [DATA_LEN-1:0]  vec_d [MAT_DIM];
    logic signed [DATA_LEN-1:0]  wb, piv;

    // Next-state, datapath and storage updates; one MAC term or one finalise per cycle.
    always_comb begin
        state_d = state_q;  mode_d = mode_q;  err_d = err_q;  first_d = first_q;
        cnt_d   = cnt_q;    j_d = j_q;  i_d = i_q;  k_d = k_q;  acc_d = acc_q;
        mat_d   = mat_q;    vec_d = vec_q;
        acc_cur = acc_q;    term = '0;  wb = '0;  piv = '0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_LOAD;  mode_d = i_mode;  err_d = 1'b0;  cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (i_valid) begin
                    if (cnt_q < C_TRI) mat_d[TIW'(cnt_q)]        = i_data;
                    else               vec_d[CW'(cnt_q - C_TRI)] = i_data;
                    if (cnt_q == (mode_q ? C_TOT_LAST : C_TRI_LAST)) begin
                        state_d = S_FACT;  j_d = '0;  i_d = '0;  k_d = '0;  first_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FACT: begin
                acc_cur = first_q ? AW'(mat_q[tidx(i_q, j_q)]) : acc_q;
                if (k_q != j_q) begin
                    term    = mul_q(sat(DW'(mul_q(mat_q[tidx(i_q, k_q)], mat_q[tidx(k_q, k_q)]))),
                                    mat_q[tidx(j_q, k_q)]);
                    acc_d   = acc_cur - term;
                    k_d     = k_q + 1'b1;
                    first_d = 1'b0;
                end else begin
                    wb = sat(DW'(acc_cur));
                    if (i_q == j_q) begin
                        mat_d[tidx(j_q, j_q)] = wb;
                    end else begin
                        piv = mat_q[tidx(j_q, j_q)];
                        if (piv == '0) err_d = 1'b1;
                        mat_d[tidx(i_q, j_q)] = sat(div_q(wb, piv));
                    end
                    first_d = 1'b1;
                    k_d     = '0;
                    if (i_q == C_LAST) begin
                        if (j_q == C_LAST) begin
                            state_d = mode_q ? S_FWD : S_OUT;
                            i_d     = '0;
                            cnt_d   = '0;
                        end else begin
                            j_d = j_q + 1'b1;
                            i_d = j_q + 1'b1;
                        end
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
            end
            S_FWD: begin
                acc_cur = first_q ? AW'(vec_q[i_q]) : acc_q;
                if (k_q != i_q) begin
                    term    = mul_q(mat_q[tidx(i_q, k_q)], vec_q[k_q]);
                    acc_d   = acc_cur - term;
                    k_d     = k_q + 1'b1;
                    first_d = 1'b0;
                end else begin
                    // y_i stays in b storage for later rows; z_i replaces d_i.
                    wb        = sat(DW'(acc_cur));
                    vec_d[i_q] = wb;
                    piv       = mat_q[tidx(i_q, i_q)];
                    if (piv == '0) err_d = 1'b1;
                    mat_d[tidx(i_q, i_q)] = sat(div_q(wb, piv));
                    first_d = 1'b1;
                    if (i_q == C_LAST) begin
                        state_d = S_BWD;  i_d = C_LAST;  k_d = C_LAST;
                    end else begin
                        i_d = i_q + 1'b1;  k_d = '0;
                    end
                end
            end
            S_BWD: begin
                acc_cur = first_q ? AW'(mat_q[tidx(i_q, i_q)]) : acc_q;
                if (k_q != i_q) begin
                    term    = mul_q(mat_q[tidx(k_q, i_q)], vec_q[k_q]);
                    acc_d   = acc_cur - term;
                    k_d     = k_q - 1'b1;
                    first_d = 1'b0;
                end else begin
                    vec_d[i_q] = sat(DW'(acc_cur));
                    first_d    = 1'b1;
                    k_d        = C_LAST;
                    if (i_q == '0) begin
                        state_d = S_OUT;  cnt_d = '0;
                    end else begin
                        i_d = i_q - 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (i_ready) begin
                    if (cnt_q == (mode_q ? C_N_LAST : C_TRI_LAST)) begin
                        state_d = S_IDLE;  cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;  mode_q <= 1'b0;  err_q <= 1'b0;  first_q <= 1'b0;
            cnt_q   <= '0;  j_q <= '0;  i_q <= '0;  k_q <= '0;  acc_q <= '0;
        end else begin
            state_q <= state_d;  mode_q <= mode_d;  err_q <= err_d;  first_q <= first_d;
            cnt_q   <= cnt_d;  j_q <= j_d;  i_q <= i_d;  k_q <= k_d;  acc_q <= acc_d;
        end
    end

    // Matrix and vector storage; contents are meaningless until loaded.
    always_ff @(posedge clk) begin
        mat_q <= mat_d;
        vec_q <= vec_d;
    end

    assign o_ready = (state_q == S_LOAD);
    assign o_valid = (state_q == S_OUT);
    assign o_busy  = (state_q != S_IDLE);
    assign o_err   = err_q;
    assign o_data  = (state_q != S_OUT) ? '0 :
                     (mode_q ? vec_q[CW'(cnt_q)] : mat_q[TIW'(cnt_q)]);
endmodule
`default_nettype wire
